// File: rtl/shared_bus_arbiter_pkg.sv
// rtl/shared_bus_arbiter_pkg.sv - shared bus address map, region and read-select types
package shared_bus_defs;

    localparam logic [15:0] GMEM_BASE  = 16'h4000;
    localparam logic [15:0] GMEM_LIMIT = 16'hBFFF;
    localparam logic [15:0] DEV_BASE   = 16'hC000;

    typedef enum logic [1:0] {
        REGION_LOCAL,
        REGION_GMEM,
        REGION_DEV
    } region_t;

    typedef enum logic {
        RD_SEL_GMEM = 1'b0,
        RD_SEL_DEV  = 1'b1
    } rd_sel_t;

    function automatic region_t decode_region(input logic [15:0] addr);
        region_t r;
        if (addr >= DEV_BASE) begin
            r = REGION_DEV;
        end else if (addr >= GMEM_BASE && addr <= GMEM_LIMIT) begin
            r = REGION_GMEM;
        end else begin
            r = REGION_LOCAL;
        end
        return r;
    endfunction

endpackage

// File: rtl/shared_bus_arbiter_if.sv
// rtl/shared_bus_arbiter_if.sv - core-side shared bus: request/grant handshake plus bus cycle
interface shared_bus_if #(
    parameter int NUM_CORES = 4
);
    logic [NUM_CORES-1:0] core_request;
    logic [NUM_CORES-1:0] core_ready;
    logic [15:0]          shared_addr;
    logic                 shared_wren;
    logic                 shared_rden;
    logic [15:0]          shared_write_val;
    logic [15:0]          shared_read_val;

    modport master (
        output core_request, shared_addr, shared_wren, shared_rden, shared_write_val,
        input  core_ready, shared_read_val
    );

    modport slave (
        input  core_request, shared_addr, shared_wren, shared_rden, shared_write_val,
        output core_ready, shared_read_val
    );
endinterface

// File: rtl/shared_bus_arbiter_rr_arbiter.sv
// rtl/shared_bus_arbiter_rr_arbiter.sv - round-robin pointer and registered one-hot grant
module rr_arbiter #(
    parameter int NUM_CORES = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_CORES-1:0] request,
    input  logic [NUM_CORES-1:0] mask,
    output logic [NUM_CORES-1:0] grant
);
    localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    logic [PTR_W-1:0]     rr_ptr;
    logic [PTR_W-1:0]     winner;
    logic [NUM_CORES-1:0] eligible;
    logic [NUM_CORES-1:0] onehot;
    logic                 found;

    assign eligible = request & ~mask;

    // Scan starting at rr_ptr so the most recent winner has lowest priority next time.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        onehot = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (!found && eligible[(int'(rr_ptr) + i) % NUM_CORES]) begin
                found  = 1'b1;
                winner = PTR_W'((int'(rr_ptr) + i) % NUM_CORES);
                onehot[(int'(rr_ptr) + i) % NUM_CORES] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            grant  <= '0;
            rr_ptr <= '0;
        end else begin
            grant <= onehot;
            if (found) begin
                rr_ptr <= (winner == PTR_W'(NUM_CORES - 1)) ? '0 : winner + 1'b1;
            end
        end
    end
endmodule

// File: rtl/shared_bus_arbiter.sv
// rtl/shared_bus_arbiter.sv - grants one core per cycle and routes its bus cycle to gmem or devices
module shared_bus_arbiter
    import shared_bus_defs::*;
#(
    parameter int NUM_CORES       = 4,
    parameter int GMEM_ADDR_WIDTH = 14
) (
    input  logic                       clk,
    input  logic                       reset_n,
    shared_bus_if.slave                bus,
    output logic [GMEM_ADDR_WIDTH-1:0] gmem_addr,
    output logic                       gmem_wren,
    output logic [15:0]                gmem_write_val,
    input  logic [15:0]                gmem_q,
    output logic [13:0]                dev_addr,
    output logic                       dev_wren,
    output logic                       dev_rden,
    output logic [15:0]                dev_write_val,
    input  logic [15:0]                dev_read_val
);
    logic    grant;
    region_t region;
    rd_sel_t rd_sel_l;
    logic    read_pending_l;

    rr_arbiter #(
        .NUM_CORES (NUM_CORES)
    ) u_rr_arbiter (
        .clk     (clk),
        .reset_n (reset_n),
        .request (bus.core_request),
        .mask    (bus.core_ready),
        .grant   (bus.core_ready)
    );

    // A grant being cancelled by reset must not reach memory or devices.
    assign grant  = reset_n & (|bus.core_ready);
    assign region = decode_region(bus.shared_addr);

    assign gmem_addr      = GMEM_ADDR_WIDTH'(bus.shared_addr - GMEM_BASE);
    assign gmem_wren      = grant & bus.shared_wren & (region == REGION_GMEM);
    assign gmem_write_val = bus.shared_write_val;

    assign dev_addr      = bus.shared_addr[13:0];
    assign dev_wren      = grant & bus.shared_wren & (region == REGION_DEV);
    assign dev_rden      = grant & bus.shared_rden & (region == REGION_DEV);
    assign dev_write_val = bus.shared_write_val;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_sel_l       <= RD_SEL_GMEM;
            read_pending_l <= 1'b0;
        end else begin
            read_pending_l <= grant & bus.shared_rden & (region != REGION_LOCAL);
            rd_sel_l       <= (grant && bus.shared_rden && region == REGION_DEV) ? RD_SEL_DEV : RD_SEL_GMEM;
        end
    end

    assign bus.shared_read_val = (read_pending_l && rd_sel_l == RD_SEL_DEV) ? dev_read_val : gmem_q;
endmodule

// File: doc/shared_bus_arbiter.md
Name: shared_bus_arbiter

Overview:
- Sits directly downstream of the cores on the shared bus.
- Arbitrates per-core shared_request lines and returns a one-hot shared_ready (grant) per core.
- Decodes the granted core's bus cycle (shared_addr / shared_wren / shared_rden / shared_write_val, driven only by the granted core) to global memory or device registers.
- Returns read data on the broadcast shared_read_val one cycle after the granted access.

Parameters:
- NUM_CORES, 4, number of requesting cores; legal range 1..16.
- GMEM_ADDR_WIDTH, 14, word-address width of the global memory port.

Ports:
- clk  input  1  clock.
- reset_n  input  1  reset: one clock; reset is synchronous and active-low.
- core_request  input  NUM_CORES  per-core shared_request.
- core_ready  output  NUM_CORES  per-core shared_ready (grant); one-hot or zero.
- shared_addr  input  16  bus address from the granted core.
- shared_wren  input  1  bus write strobe.
- shared_rden  input  1  bus read strobe.
- shared_write_val  input  16  bus write data.
- shared_read_val  output  16  read data broadcast to all cores.
- gmem_addr  output  GMEM_ADDR_WIDTH  global memory word address.
- gmem_wren  output  1  global memory write enable.
- gmem_write_val  output  16  global memory write data.
- gmem_q  input  16  global memory read data; synchronous read, 1-cycle latency.
- dev_addr  output  14  device register address, shared_addr[13:0].
- dev_wren  output  1  device write strobe.
- dev_rden  output  1  device read strobe.
- dev_write_val  output  16  device write data.
- dev_read_val  input  16  device read data, registered by device, 1-cycle latency.

Behaviour:
- Address map:
  - 0x4000-0xBFFF is global memory; gmem_addr = shared_addr - 0x4000, truncated to GMEM_ADDR_WIDTH.
  - 0xC000-0xFFFF is device registers.
  - 0x0000-0x3FFF never reaches the bus (core-local).
- Reset (reset_n low at a clk edge):
  - core_ready=0, rr_ptr=0, rd_sel_l=GMEM, read_pending_l=0.
  - shared_read_val=gmem_q (read_pending_l=0).
  - All strobes 0.
  - Reset asserted mid-grant cancels the grant at that edge; the bus cycle is dropped.
- Grant is registered. At each edge, eligible = core_request & ~core_ready.
  - The core currently granted is masked for that edge, because its request during the grant cycle is the access being served.
  - If eligible is nonzero, core_ready <= one-hot of the first eligible index at or after rr_ptr (wrapping NUM_CORES-1 -> 0), and rr_ptr <= winner+1 mod NUM_CORES.
  - If eligible is zero, core_ready <= 0 and rr_ptr holds.
- Grant lasts exactly one cycle; the core completes its access in that cycle.
  - Minimum latency from request to access is 1 stall cycle.
  - Different cores may be granted on consecutive cycles.
  - A single core gets at most one grant per 2 cycles.
- Starvation bound: a continuously requesting core is granted within NUM_CORES+1 cycles of first request.
- Strobes are combinational from bus inputs, gated by |core_ready:
  - gmem_wren = grant & shared_wren & map==GMEM.
  - dev_wren and dev_rden follow the same rule for map==DEV.
  - With no grant, all strobes are 0 and bus inputs are ignored (floating).
- A grant cycle with neither shared_wren nor shared_rden is legal and produces no strobe.
- Read return: rd_sel_l and read_pending_l are registered from the grant-cycle decode.
  - The next cycle, shared_read_val = rd_sel_l==DEV ? dev_read_val : gmem_q.
  - When read_pending_l=0, shared_read_val = gmem_q (don't-care for cores).
- Simultaneous wren and rden in a grant cycle is illegal; the write takes priority, and the read strobe is still issued.

Decomposition:
- Package shared_bus_defs holds:
  - address-map constants: GMEM_BASE=16'h4000, GMEM_LIMIT=16'hBFFF, DEV_BASE=16'hC000;
  - region enum {REGION_LOCAL, REGION_GMEM, REGION_DEV};
  - rd_sel encoding.
- Sub-module rr_arbiter(NUM_CORES) holds rr_ptr and the one-hot registered grant, with inputs request and mask.
- The top level holds decode, strobe gating and the read-return register.

Test Plan:
- Reset with core_request=4'b1111 held: core_ready=0 while reset_n=0. First edge after release grants core 0. Following grants go 1, 2, 3, 0 on consecutive cycles while requests stay high.
- Single request: core 2 raises request at cycle N with a write to 0x4010, data 0xBEEF. core_ready=4'b0100 in N+1, with gmem_wren=1 and gmem_addr=0x0010 in N+1. core_ready=0 in N+2 if the request drops.
- Device read: core 1 reads 0xC005 while the device returns 0x1234. dev_rden=1 and dev_addr=0x0005 in the grant cycle; shared_read_val=0x1234 the next cycle.
- Back-to-back same core: core 0 requests continuously with others idle. Grants occur every other cycle (1,0,1,0); no double grant on the cycle after a grant.
- Fairness: cores 0 and 3 request continuously. Grants alternate 3 and 0 in round-robin order; neither waits more than 5 cycles.
- Reset mid-grant: assert reset_n=0 in a grant cycle carrying a write. core_ready=0 next cycle and rr_ptr=0. The post-reset first grant goes to the lowest requesting index.
